// File: rtl/early_debouncer_if.sv
// Switch-side signal bundle for early_debouncer: raw input and timebase in,
// clean level, edge pulses and lockout status out.
interface early_debouncer_if;
  logic sw;
  logic tick;
  logic db;
  logic db_rise;
  logic db_fall;
  logic busy;

  modport master (output sw, tick, input db, db_rise, db_fall, busy);
  modport slave  (input sw, tick, output db, db_rise, db_fall, busy);
endinterface

// File: rtl/early_debouncer.sv
// Leading-edge switch debouncer: passes the first edge at once, then ignores the
// input for N_TICKS timebase ticks. Define EARLY_DB_SYNC_EN to add a 2-flop input synchronizer.
module early_debouncer #(
  parameter int N_TICKS = 20
) (
  input  logic           clk,
  input  logic           reset_n,
  early_debouncer_if.slave bus
);

  localparam int CW = $clog2(N_TICKS + 1);

  if (N_TICKS < 1) begin : g_bad_n_ticks
    $error("early_debouncer: N_TICKS must be >= 1");
  end

  typedef enum logic [1:0] {
    ZERO  = 2'd0,
    WAIT1 = 2'd1,
    ONE   = 2'd2,
    WAIT0 = 2'd3
  } state_t;

  state_t        state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic          rise_q, rise_nx;
  logic          fall_q, fall_nx;
  logic          sw_s;

`ifdef EARLY_DB_SYNC_EN
  logic [1:0] sync_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) sync_q <= '0;
    else          sync_q <= {sync_q[0], bus.sw};
  end

  assign sw_s = sync_q[1];
`else
  assign sw_s = bus.sw;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= ZERO;
      cnt    <= '0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      state  <= state_nx;
      cnt    <= cnt_nx;
      rise_q <= rise_nx;
      fall_q <= fall_nx;
    end
  end

  // The counter is cleared on entry to a WAIT state, so a tick coinciding with
  // entry is never counted; exit happens on the N_TICKS-th counted tick.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    rise_nx  = 1'b0;
    fall_nx  = 1'b0;
    unique case (state)
      ZERO: begin
        if (sw_s) begin
          state_nx = WAIT1;
          cnt_nx   = '0;
          rise_nx  = 1'b1;
        end
      end
      WAIT1: begin
        if (bus.tick) begin
          if (cnt == CW'(N_TICKS - 1)) state_nx = ONE;
          else                         cnt_nx   = cnt + CW'(1);
        end
      end
      ONE: begin
        if (!sw_s) begin
          state_nx = WAIT0;
          cnt_nx   = '0;
          fall_nx  = 1'b1;
        end
      end
      WAIT0: begin
        if (bus.tick) begin
          if (cnt == CW'(N_TICKS - 1)) state_nx = ZERO;
          else                         cnt_nx   = cnt + CW'(1);
        end
      end
      default: state_nx = ZERO;
    endcase
  end

  assign bus.db      = (state == WAIT1) || (state == ONE);
  assign bus.busy    = (state == WAIT1) || (state == WAIT0);
  assign bus.db_rise = rise_q;
  assign bus.db_fall = fall_q;

endmodule
